// File: rtl/decoder_seq_nxm.sv
// decoder_seq_nxm: registered N-to-M enabled decoder with valid/ready handshake and a scan sweep.
// Define DECODER_ERR_EN to add the sticky out-of-range flag (err_clr_i / err_o).
module decoder_seq_nxm #(
  parameter int INPUT_LENGTH = 4,
  parameter int NUM_OUTPUTS  = 2**INPUT_LENGTH
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [INPUT_LENGTH-1:0] in_i,
  input  logic                    enable_i,
  input  logic                    scan_start_i,
  output logic [NUM_OUTPUTS-1:0]  out_o,
  output logic                    valid_o,
  output logic                    busy_o,
`ifdef DECODER_ERR_EN
  output logic                    scan_done_o,
  input  logic                    err_clr_i,
  output logic                    err_o
`else
  output logic                    scan_done_o
`endif
);

  localparam int CNT_W = $clog2(NUM_OUTPUTS) + 1;
  localparam int CODE_W = INPUT_LENGTH + 1;
  localparam logic [CODE_W-1:0]      CODE_LIMIT = CODE_W'(NUM_OUTPUTS);
  localparam logic [CNT_W-1:0]       LAST_IDX   = CNT_W'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] STROBE0    = {{(NUM_OUTPUTS-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN,
    ST_SCAN
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   in_range;

  // Widen by one bit so NUM_OUTPUTS == 2**INPUT_LENGTH still compares unsigned and correctly.
  assign in_range = ({1'b0, in_i} < CODE_LIMIT);
  assign ready_o  = (state_q == ST_RUN) & ~scan_start_i;
  assign accept   = valid_i & ready_o;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (scan_start_i) begin
          state_d = ST_SCAN;
          out_d   = STROBE0;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end else if (accept) begin
          valid_d = 1'b1;
          if (enable_i && in_range) out_d = STROBE0 << in_i;
        end
      end
      ST_SCAN: begin
        out_d   = STROBE0 << cnt_q;
        valid_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_o       = out_q;
  assign valid_o     = valid_q;
  assign scan_done_o = done_q;
  // The FSM is already back in RUN while the last scan strobe is shown; busy covers that strobe too.
  assign busy_o      = (state_q == ST_SCAN) | done_q;

`ifdef DECODER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (accept && enable_i && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule
